mem_arbiter: RTL

//  Shares the single word-wide main-memory port between I-cache and D-cache line traffic.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_line_buf.sv | 38 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: arbiter state encoding, owner codes and line-size default.
// MEM_ARB_ROUND_ROBIN_EN (see mem_arbiter) does not change anything in this package.
package mem_arbiter_pkg;

    localparam int unsigned LineWordsDef = 4;

    typedef enum logic [2:0] {
        ArbIdle = 3'd0,
        ArbIRd  = 3'd1,
        ArbDRd  = 3'd2,
        ArbDWr  = 3'd3,
        ArbDone = 3'd4
    } arb_state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

    function automatic logic is_burst(input arb_state_e s);
        return (s == ArbIRd) || (s == ArbDRd) || (s == ArbDWr);
    endfunction

endpackage

// File: rtl/mem_arb_line_buf.sv
// One cache line of LINE_WORDS words: indexed single-word write, whole-line load, line read.
// Load takes precedence over the word write.
module mem_arb_line_buf #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
    input  logic [WORD_W-1:0]            wr_word_i,
    input  logic                         load_en_i,
    input  logic [WORD_W*LINE_WORDS-1:0] load_line_i,
    output logic [WORD_W*LINE_WORDS-1:0] line_o
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_en_i) begin
            line_d = load_line_i;
        end else if (wr_en_i) begin
            line_d[wr_idx_i] = wr_word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line traffic onto one word-wide memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to arbitrate simultaneous requests round-robin instead of D > I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LINE_WORDS = LineWordsDef
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_ready,
    output logic [WORD_W*LINE_WORDS-1:0] i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [WORD_W*LINE_WORDS-1:0] d_wdata,
    output logic                         d_ready,
    output logic [WORD_W*LINE_WORDS-1:0] d_rdata,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [WORD_W-1:0]            mem_rdata,
    input  logic                         mem_rvalid,
    input  logic                         mem_wack,
    output logic                         busy_i,
    output logic                         busy_d
);

    localparam int unsigned IdxW = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(LINE_WORDS - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;

    logic pick_d;
    logic i_wr_en, d_wr_en, d_load_en;
    logic [WORD_W*LINE_WORDS-1:0] d_line;
    logic [LINE_WORDS-1:0][WORD_W-1:0] d_words;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_fav_d_q, rr_fav_d_d;
    assign pick_d = d_req & (rr_fav_d_q | ~i_req);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        i_wr_en   = 1'b0;
        d_wr_en   = 1'b0;
        d_load_en = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_fav_d_d = rr_fav_d_q;
`endif
        unique case (state_q)
            ArbIdle: begin
                if (i_req || d_req) begin
                    owner_d   = pick_d ? OwnD : OwnI;
                    base_d    = (pick_d ? d_addr : i_addr) & ~OffMask;
                    cnt_d     = '0;
                    // The D buffer doubles as the latched writeback copy.
                    d_load_en = pick_d & d_we;
                    if (!pick_d) begin
                        state_d = ArbIRd;
                    end else if (d_we) begin
                        state_d = ArbDWr;
                    end else begin
                        state_d = ArbDRd;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_fav_d_d = ~pick_d;
`endif
                end
            end
            ArbIRd, ArbDRd: begin
                if (mem_rvalid) begin
                    i_wr_en = (state_q == ArbIRd);
                    d_wr_en = (state_q == ArbDRd);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = ArbDone;
                    end
                end
            end
            ArbDWr: begin
                if (mem_wack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = ArbDone;
                    end
                end
            end
            ArbDone: state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ArbIdle;
            owner_q <= OwnI;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_fav_d_q <= 1'b1;
        end else begin
            rr_fav_d_q <= rr_fav_d_d;
        end
    end
`endif

    mem_arb_line_buf #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_i_buf (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .wr_en_i     (i_wr_en),
        .wr_idx_i    (cnt_q),
        .wr_word_i   (mem_rdata),
        .load_en_i   (1'b0),
        .load_line_i ('0),
        .line_o      (i_rdata)
    );

    mem_arb_line_buf #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_d_buf (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .wr_en_i     (d_wr_en),
        .wr_idx_i    (cnt_q),
        .wr_word_i   (mem_rdata),
        .load_en_i   (d_load_en),
        .load_line_i (d_wdata),
        .line_o      (d_line)
    );

    assign d_words = d_line;
    assign d_rdata = d_line;

    // The response cycle doubles as the one-cycle gap between word handshakes.
    assign mem_read  = ((state_q == ArbIRd) || (state_q == ArbDRd)) && !mem_rvalid;
    assign mem_write = (state_q == ArbDWr) && !mem_wack;
    assign mem_addr  = is_burst(state_q) ? base_q + ADDR_W'(cnt_q) : '0;
    assign mem_wdata = (state_q == ArbDWr) ? d_words[cnt_q] : '0;

    assign i_ready = (state_q == ArbDone) && (owner_q == OwnI);
    assign d_ready = (state_q == ArbDone) && (owner_q == OwnD);
    assign busy_i  = (state_q != ArbIdle) && (owner_q == OwnI);
    assign busy_d  = (state_q != ArbIdle) && (owner_q == OwnD);

endmodule
